dmem_responder: RTL and testbench

- Memory-side responder for the MEM stage's data-memory requests. The MEM-stage control supplies rw, store_sel and load width; this block answers.
- Holds a word-organised data RAM and accepts one request at a time over a valid/ready handshake. Each access takes a fixed, parameterised latency.
- Stores perform byte-lane merging. Loads return aligned, sign- or zero-extended data ready for writeback.
- Sits between the MEM pipeline stage and the writeback mux.

---
 rtl/dmem_responder_pkg.sv | 52 +++++
 rtl/dmem_load_align.sv | 26 ++
 rtl/dmem_responder.sv | 139 +++++++++++++
 tb/tb_dmem_responder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared codes for the data-memory responder: access-type encodings, load funct3
// values, FSM states and the latched request record.
package dmem_responder_pkg;

   localparam logic MEM_READ  = 1'b0;
   localparam logic MEM_WRITE = 1'b1;

   localparam logic [1:0] STORE_B = 2'b00;
   localparam logic [1:0] STORE_H = 2'b01;
   localparam logic [1:0] STORE_W = 2'b10;

   localparam logic [2:0] SB = 3'd0;
   localparam logic [2:0] SH = 3'd1;

   localparam logic [2:0] LB  = 3'd0;
   localparam logic [2:0] LH  = 3'd1;
   localparam logic [2:0] LW  = 3'd2;
   localparam logic [2:0] LBU = 3'd4;
   localparam logic [2:0] LHU = 3'd5;

   typedef enum logic [1:0] {
      DMEM_IDLE = 2'd0,
      DMEM_WAIT = 2'd1,
      DMEM_RESP = 2'd2
   } dmem_state_e;

   typedef struct packed {
      logic        rw;
      logic [1:0]  store_sel;
      logic [2:0]  funct3;
      logic [31:0] addr;
      logic [31:0] wdata;
   } dmem_req_t;

   // Unassigned store_sel and funct3 codes fall through to word-sized accesses.
   function automatic logic is_misaligned(input logic       rw,
                                          input logic [1:0] store_sel,
                                          input logic [2:0] funct3,
                                          input logic [1:0] offset);
      logic half;
      logic word;
      if (rw == MEM_WRITE) begin
         half = (store_sel == STORE_H);
         word = (store_sel != STORE_H) && (store_sel != STORE_B);
      end else begin
         half = (funct3 == LH) || (funct3 == LHU);
         word = !half && (funct3 != LB) && (funct3 != LBU);
      end
      return (half && offset[0]) || (word && (offset != 2'b00));
   endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load alignment: shifts the addressed lane down to bit 0 and sign/zero extends it.
// Shared with the writeback stage.
module dmem_load_align
   import dmem_responder_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   output logic [31:0] data
);

   logic [31:0] shifted;

   // NOTE: every output gets a value on every path, so no latch is inferred.
   always_comb begin
      shifted = word >> {offset, 3'b000};
      case (funct3)
         LB:      data = {{24{shifted[7]}}, shifted[7:0]};
         LH:      data = {{16{shifted[15]}}, shifted[15:0]};
         LBU:     data = {24'h0, shifted[7:0]};
         LHU:     data = {16'h0, shifted[15:0]};
         default: data = word;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: one request at a time, fixed latency,
// byte-lane merging stores and aligned/extended loads.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        rw,
   input  logic [1:0]  store_sel,
   input  logic [2:0]  load_funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        resp_valid,
   output logic [31:0] rdata,
   output logic        misaligned
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   dmem_state_e   state_q;
   dmem_state_e   state_d;
   logic [CW-1:0] cnt_q;
   dmem_req_t     req_q;

   logic          accept;
   logic          access;
   logic          fault;
   logic          wr_en;
   logic [1:0]    offset;
   logic [AW-1:0] idx;
   logic [3:0]    lane_en;
   logic [31:0]   lane_data;
   logic [31:0]   lane_mask;
   logic [31:0]   rd_word;
   logic [31:0]   merged;
   logic [31:0]   load_data;
   logic          unused_addr_hi;

   logic [31:0]   mem [DEPTH_WORDS];

   assign req_ready = (state_q == DMEM_IDLE);
   assign accept    = req_ready && req_valid;

   // Upper address bits alias onto the RAM and are deliberately ignored.
   assign offset         = req_q.addr[1:0];
   assign idx            = req_q.addr[AW+1:2];
   assign unused_addr_hi = ^req_q.addr[31:AW+2];

   assign fault   = is_misaligned(req_q.rw, req_q.store_sel, req_q.funct3, offset);
   assign wr_en   = access && (req_q.rw == MEM_WRITE) && !fault;
   assign rd_word = mem[idx];

   always_comb begin
      state_d = state_q;
      access  = 1'b0;
      case (state_q)
         DMEM_IDLE: if (req_valid) state_d = DMEM_WAIT;
         DMEM_WAIT: begin
            if (cnt_q == '0) begin
               access  = 1'b1;
               state_d = DMEM_RESP;
            end
         end
         DMEM_RESP: state_d = DMEM_IDLE;
         default:   state_d = DMEM_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state_q <= DMEM_IDLE;
      else          state_q <= state_d;
   end

   // Store data is replicated across lanes; the lane mask picks what actually lands.
   always_comb begin
      lane_en   = 4'b1111;
      lane_data = req_q.wdata;
      lane_mask = '0;
      case (req_q.store_sel)
         STORE_B: begin
            lane_en   = 4'b0001 << offset;
            lane_data = {4{req_q.wdata[7:0]}};
         end
         STORE_H: begin
            lane_en   = offset[1] ? 4'b1100 : 4'b0011;
            lane_data = {2{req_q.wdata[15:0]}};
         end
         default: ;
      endcase
      for (int l = 0; l < 4; l++) lane_mask[8*l +: 8] = {8{lane_en[l]}};
   end

   assign merged = (rd_word & ~lane_mask) | (lane_data & lane_mask);

   // NOTE: the RAM array has no reset; contents survive reset_n, and only a
   // committed access (state already out of reset) can write it.
   always_ff @(posedge clock) begin
      if (wr_en) mem[idx] <= merged;
   end

   dmem_load_align u_align (
      .word   (rd_word),
      .offset (offset),
      .funct3 (req_q.funct3),
      .data   (load_data)
   );

   // NOTE: all sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q      <= '0;
         req_q      <= '0;
         resp_valid <= 1'b0;
         rdata      <= '0;
         misaligned <= 1'b0;
      end else begin
         resp_valid <= access;
         if (accept) begin
            cnt_q <= CW'(LATENCY - 1);
            req_q <= '{rw: rw, store_sel: store_sel, funct3: load_funct3,
                       addr: addr, wdata: wdata};
         end else if ((state_q == DMEM_WAIT) && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
         end
         if (access) begin
            rdata      <= ((req_q.rw == MEM_READ) && !fault) ? load_data : '0;
            misaligned <= fault;
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vectors plus a byte-level
// reference model feeding a response scoreboard.
module tb_dmem_responder;
   import dmem_responder_pkg::*;

   localparam int DEPTH = 1024;
   localparam int LAT   = 2;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        rw = MEM_READ;
   logic [1:0]  store_sel = STORE_W;
   logic [2:0]  load_funct3 = LW;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic        resp_valid;
   logic [31:0] rdata;
   logic        misaligned;

   always #5 clock = ~clock;

   dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .rw          (rw),
      .store_sel   (store_sel),
      .load_funct3 (load_funct3),
      .addr        (addr),
      .wdata       (wdata),
      .resp_valid  (resp_valid),
      .rdata       (rdata),
      .misaligned  (misaligned)
   );

   typedef struct {
      string       tag;
      logic [31:0] rdata;
      logic        mis;
      int          cyc;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] mdl [0:4*DEPTH-1];
   int         n_checks = 0;
   int         n_errors = 0;
   int         cyc = 0;
   int         n_hs = 0;
   int         last_acc_cyc = 0;

   always @(posedge clock) cyc <= cyc + 1;
   always @(negedge clock) if (reset_n && req_valid && req_ready) n_hs <= n_hs + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // Byte-array reference: stores write bytes, loads gather and extend.
   function automatic void model(input logic r, input logic [1:0] s, input logic [2:0] f,
                                 input logic [31:0] a, input logic [31:0] d,
                                 output logic [31:0] rd, output logic mis);
      int          nb;
      int          base;
      logic [31:0] v;
      if (r == MEM_WRITE) nb = (s == STORE_B) ? 1 : (s == STORE_H) ? 2 : 4;
      else                nb = (f == LB || f == LBU) ? 1 : (f == LH || f == LHU) ? 2 : 4;
      mis  = (int'(a[1:0]) % nb) != 0;
      base = int'(a & 32'(4*DEPTH-1));
      rd   = '0;
      if (mis) return;
      if (r == MEM_WRITE) begin
         for (int i = 0; i < nb; i++) mdl[base+i] = d[8*i +: 8];
      end else begin
         v = '0;
         for (int i = 0; i < nb; i++) v[8*i +: 8] = mdl[base+i];
         if (f == LB) v = {{24{v[7]}}, v[7:0]};
         if (f == LH) v = {{16{v[15]}}, v[15:0]};
         rd = v;
      end
   endfunction

   task automatic do_req(input string tag, input logic r, input logic [1:0] s,
                         input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                         input logic lit, input logic [31:0] x_rd, input logic x_mis);
      exp_t        e;
      logic [31:0] m_rd;
      logic        m_mis;
      int          waited;
      @(negedge clock);
      req_valid   = 1'b1;
      rw          = r;
      store_sel   = s;
      load_funct3 = f;
      addr        = a;
      wdata       = d;
      waited      = 0;
      while (!req_ready && waited < 100) begin
         @(negedge clock);
         waited++;
      end
      if (!req_ready) begin
         check({tag, "_accept_timeout"}, 32'd0, 32'd1);
         req_valid = 1'b0;
         return;
      end
      model(r, s, f, a, d, m_rd, m_mis);
      e.tag   = tag;
      e.rdata = lit ? x_rd : m_rd;
      e.mis   = lit ? x_mis : m_mis;
      e.cyc   = cyc + 1 + LAT;
      last_acc_cyc = cyc + 1;
      exp_q.push_back(e);
      @(posedge clock);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int w = 0;
      while (exp_q.size() != 0 && w < 100) begin
         @(negedge clock);
         w++;
      end
      if (exp_q.size() != 0) begin
         check("drain_timeout", 32'(exp_q.size()), 32'd0);
         exp_q.delete();
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (resp_valid) begin
            if (exp_q.size() == 0) begin
               check("spurious_resp", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check({e.tag, "_rdata"}, rdata, e.rdata);
               check({e.tag, "_misaligned"}, 32'(misaligned), 32'(e.mis));
               check({e.tag, "_latency"}, 32'(cyc), 32'(e.cyc));
               check({e.tag, "_ready_in_resp"}, 32'(req_ready), 32'd0);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        rr;
      logic [1:0]  rs;
      logic [2:0]  rf;
      logic [31:0] ra;
      int          a1;
      int          hs0;

      repeat (3) @(negedge clock);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_misaligned", 32'(misaligned), 32'd0);
      check("rst_ready", 32'(req_ready), 32'd1);
      reset_n = 1'b1;

      do_req("pre_sw10", MEM_WRITE, STORE_W, LW, 32'h10, 32'h0BADF00D, 1'b1, 32'h0, 1'b0);
      wait_drain();

      // Abort a pending store with reset while it sits in WAIT.
      @(negedge clock);
      req_valid = 1'b1; rw = MEM_WRITE; store_sel = STORE_W; addr = 32'h10; wdata = 32'hDEADBEEF;
      @(posedge clock);
      #1 req_valid = 1'b0;
      @(negedge clock);
      reset_n = 1'b0;
      repeat (3) begin
         @(posedge clock);
         #1 check("abort_resp_valid", 32'(resp_valid), 32'd0);
      end
      check("abort_rdata", rdata, 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock);
      #1 check("ready_after_release", 32'(req_ready), 32'd1);
      do_req("abort_lw10", MEM_READ, STORE_W, LW, 32'h10, 32'h0, 1'b1, 32'h0BADF00D, 1'b0);
      wait_drain();

      // Latency and busy window.
      do_req("lat_sw20", MEM_WRITE, STORE_W, LW, 32'h20, 32'h11223344, 1'b1, 32'h0, 1'b0);
      check("ready_e0", 32'(req_ready), 32'd0);
      repeat (2) begin
         @(posedge clock);
         #1 check("ready_busy", 32'(req_ready), 32'd0);
      end
      @(posedge clock);
      #1 check("ready_idle", 32'(req_ready), 32'd1);
      wait_drain();

      do_req("sb21", MEM_WRITE, STORE_B, LW, 32'h21, 32'h000000AA, 1'b1, 32'h0, 1'b0);
      do_req("sh22", MEM_WRITE, STORE_H, LW, 32'h22, 32'h0000BEEF, 1'b1, 32'h0, 1'b0);
      do_req("merge_lw20", MEM_READ, STORE_W, LW, 32'h20, 32'h0, 1'b1, 32'hBEEFAA44, 1'b0);

      do_req("sw40", MEM_WRITE, STORE_W, LW, 32'h40, 32'h80FF7F01, 1'b1, 32'h0, 1'b0);
      do_req("lb41", MEM_READ, STORE_W, LB, 32'h41, 32'h0, 1'b1, 32'h0000007F, 1'b0);
      do_req("lb42", MEM_READ, STORE_W, LB, 32'h42, 32'h0, 1'b1, 32'hFFFFFFFF, 1'b0);
      do_req("lbu43", MEM_READ, STORE_W, LBU, 32'h43, 32'h0, 1'b1, 32'h00000080, 1'b0);
      do_req("lh42", MEM_READ, STORE_W, LH, 32'h42, 32'h0, 1'b1, 32'hFFFF80FF, 1'b0);
      do_req("lhu42", MEM_READ, STORE_W, LHU, 32'h42, 32'h0, 1'b1, 32'h000080FF, 1'b0);

      do_req("lw41_mis", MEM_READ, STORE_W, LW, 32'h41, 32'h0, 1'b1, 32'h0, 1'b1);
      do_req("sh43_mis", MEM_WRITE, STORE_H, LW, 32'h43, 32'h00001234, 1'b1, 32'h0, 1'b1);
      do_req("lw40_kept", MEM_READ, STORE_W, LW, 32'h40, 32'h0, 1'b1, 32'h80FF7F01, 1'b0);
      do_req("lh41_mis", MEM_READ, STORE_W, LH, 32'h41, 32'h0, 1'b1, 32'h0, 1'b1);
      do_req("f3_3_mis", MEM_READ, STORE_W, 3'd3, 32'h42, 32'h0, 1'b1, 32'h0, 1'b1);
      do_req("f3_6_lw", MEM_READ, STORE_W, 3'd6, 32'h40, 32'h0, 1'b1, 32'h80FF7F01, 1'b0);
      wait_drain();

      // Second request held valid while the first is still in flight.
      hs0 = n_hs;
      do_req("bp_first", MEM_READ, STORE_W, LW, 32'h40, 32'h0, 1'b1, 32'h80FF7F01, 1'b0);
      a1 = last_acc_cyc;
      do_req("bp_second", MEM_READ, STORE_W, LBU, 32'h41, 32'h0, 1'b1, 32'h0000007F, 1'b0);
      check("bp_spacing", 32'(last_acc_cyc - a1), 32'(LAT + 2));
      wait_drain();
      check("bp_handshakes", 32'(n_hs - hs0), 32'd2);

      do_req("alias_sw", MEM_WRITE, STORE_W, LW, 32'h1000, 32'h5A5A5A5A, 1'b1, 32'h0, 1'b0);
      do_req("alias_lw0", MEM_READ, STORE_W, LW, 32'h0, 32'h0, 1'b1, 32'h5A5A5A5A, 1'b0);
      wait_drain();

      for (int i = 0; i < 16; i++)
         do_req("fill", MEM_WRITE, STORE_W, LW, 32'h100 + 32'(4*i), $urandom(), 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 40; i++) begin
         rr = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 2))
            0:       rs = STORE_B;
            1:       rs = STORE_H;
            default: rs = STORE_W;
         endcase
         rf = 3'($urandom_range(0, 7));
         ra = 32'h100 + 32'($urandom_range(0, 63)) + (32'($urandom_range(0, 3)) << 12);
         do_req("rnd", rr, rs, rf, ra, $urandom(), 1'b0, 32'h0, 1'b0);
      end
      wait_drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
